// File: rtl/serial_cmp_driver.sv
// Initiator side of the bit-serial tri-state compare path: MSB-first bit-pair driver with internal EQ/GT/LT tracking.
// Optional early termination on first decision: define SERIAL_CMP_EARLY_TERM_EN.
module serial_cmp_driver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           op_a,
    input  logic [WIDTH-1:0]           op_b,
    input  logic [1:0]                 cas_in,
    output logic                       ser_a,
    output logic                       ser_b,
    output logic                       ser_valid,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 result,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [1:0]       cmp_q, cmp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [1:0]       result_q, result_d;
    logic [1:0]       cmp_upd;
    logic             finish;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cmp_q    <= CMP_EQ;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= CMP_EQ;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state, verdict tracking and shift control
    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;

        // First differing bit pair decides; a non-EQ seed is never overwritten
        cmp_upd = cmp_q;
        if ((cmp_q == CMP_EQ) && (sh_a_q[WIDTH-1] != sh_b_q[WIDTH-1])) begin
            cmp_upd = sh_a_q[WIDTH-1] ? CMP_GT : CMP_LT;
        end

        finish = (cnt_q == '0);
`ifdef SERIAL_CMP_EARLY_TERM_EN
        finish = finish || (cmp_upd != CMP_EQ);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    cmp_d   = (cas_in == 2'b11) ? CMP_EQ : cas_in;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cmp_d  = cmp_upd;
                sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
                sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
                if (finish) begin
                    // Clear the shifters so the serial lines idle low after an early exit
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = cmp_upd;
                    cnt_d    = '0;
                    sh_a_d   = '0;
                    sh_b_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    assign ser_a     = sh_a_q[WIDTH-1];
    assign ser_b     = sh_b_q[WIDTH-1];
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign result    = result_q;
    assign bit_idx   = cnt_q;

endmodule

// File: tb/tb_serial_cmp_driver.sv
// Scoreboard bench for serial_cmp_driver: stimulus pushes hand-computed verdicts, a negedge monitor checks serial traffic and done.
module tb_serial_cmp_driver;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [1:0]    cas_in = 2'b00;
    logic          ser_a, ser_b, ser_valid, busy, done;
    logic [1:0]    result;
    logic [IW-1:0] bit_idx;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   res;
        int           len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int       n_bits = 0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;

    always #5 clk = ~clk;

    serial_cmp_driver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cas_in    (cas_in),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .bit_idx   (bit_idx)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] res,
                            input int len_def, input int len_et);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.res = res;
`ifdef SERIAL_CMP_EARLY_TERM_EN
        e.len = len_et;
`else
        e.len = len_def;
`endif
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ser_a"}, ser_a, 0);
        chk({tag, "_ser_b"}, ser_b, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_bit_idx"}, bit_idx, 0);
    endtask

    // Returns at a falling edge with busy low (bounded)
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout busy=%0b exp=0", busy);
        end
    endtask

    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] cas,
                          input logic [1:0] res, input int len_def, input int len_et);
        wait_idle();
        op_a   = a;
        op_b   = b;
        cas_in = cas;
        start  = 1'b1;
        push_exp(a, b, res, len_def, len_et);
        @(negedge clk);
        start  = 1'b0;
        // Scramble inputs after acceptance; the compare in flight must not notice
        op_a   = ~a;
        op_b   = ~b;
        cas_in = 2'b10;
    endtask

    // Monitor: collect serial pairs, score each done against the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            n_bits = 0;
            cap_a  = '0;
            cap_b  = '0;
        end else begin
            if (ser_valid) begin
                chk("bit_idx", bit_idx, W - 1 - n_bits);
                cap_a = {cap_a[W-2:0], ser_a};
                cap_b = {cap_b[W-2:0], ser_b};
                n_bits++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done result=%0h exp=none", result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("shift_len", n_bits, e.len);
                    chk("ser_a_seq", cap_a, e.a >> (W - e.len));
                    chk("ser_b_seq", cap_b, e.b >> (W - e.len));
                end
                n_bits = 0;
                cap_a  = '0;
                cap_b  = '0;
            end
        end
    end

    initial begin
        int n;
        logic [W-1:0] ab_a, ab_b;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_cmp(8'h5A, 8'h5A, 2'b00, 2'b00, 8, 8);
        do_cmp(8'h80, 8'h7F, 2'b00, 2'b01, 8, 1);
        do_cmp(8'h12, 8'h13, 2'b00, 2'b10, 8, 8);
        do_cmp(8'h00, 8'hFF, 2'b01, 2'b01, 8, 1);
        do_cmp(8'h00, 8'hFF, 2'b11, 2'b10, 8, 1);

        // Start held high: second compare launches in the done cycle, mid-shift toggles ignored
        wait_idle();
        op_a   = 8'h01;
        op_b   = 8'h02;
        cas_in = 2'b00;
        start  = 1'b1;
        push_exp(8'h01, 8'h02, 2'b10, 8, 7);
        @(negedge clk);
        op_a = 8'h03;
        op_b = 8'h03;
        repeat (3) begin
            @(negedge clk);
            start = ~start;
        end
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", done, 1);
        chk("b2b_idle_in_done_cycle", busy, 0);
        push_exp(8'h03, 8'h03, 2'b00, 8, 8);
        @(negedge clk);
        chk("b2b_accepted", busy, 1);
        start = 1'b0;

        // Abort mid-shift with reset
`ifdef SERIAL_CMP_EARLY_TERM_EN
        ab_a = 8'hF0;
        ab_b = 8'hF0;
`else
        ab_a = 8'hF0;
        ab_b = 8'h0F;
`endif
        wait_idle();
        op_a   = ab_a;
        op_b   = ab_b;
        cas_in = 2'b00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(ser_valid && bit_idx == IW'(4)) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_idx4", bit_idx, 4);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk("abort_no_done", done, 0);
        rst_n = 1'b1;

        do_cmp(8'h0F, 8'hF0, 2'b00, 2'b10, 8, 1);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("result_held", result, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
